// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    S_RUN,
    S_MEM_WAIT
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: register ids, stage flags and stall/flush controls.
// The controller attaches via the slave modport; the pipeline (or a bench) uses master.
interface hazard_ctrl_if #(
    parameter int unsigned PERF_W = 32
);
    logic [4:0]        Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic              StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              mem_err;
    logic [PERF_W-1:0] perf_lu_cnt, perf_flush_cnt, perf_wait_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE,
        input  ForwardAE, ForwardBE, mem_err,
        input  perf_lu_cnt, perf_flush_cnt, perf_wait_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE,
        output ForwardAE, ForwardBE, mem_err,
        output perf_lu_cnt, perf_flush_cnt, perf_wait_cnt
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward select for one EX operand; the Memory stage wins over Writeback.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, branch flush, memory-wait freeze.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned PERF_W      = 32  // must match the interface PERF_W
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          lu;
    logic [1:0]    fwd_a, fwd_b;

    hazard_fwd_sel u_fwd_a (
        .rs          (hz.Rs1E),
        .rd_m        (hz.RdM),
        .reg_write_m (hz.RegWriteM),
        .rd_w        (hz.RdW),
        .reg_write_w (hz.RegWriteW),
        .fwd         (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs          (hz.Rs2E),
        .rd_m        (hz.RdM),
        .reg_write_m (hz.RegWriteM),
        .rd_w        (hz.RdW),
        .reg_write_w (hz.RegWriteW),
        .fwd         (fwd_b)
    );

    assign hz.ForwardAE = rst ? FWD_RF : fwd_a;
    assign hz.ForwardBE = rst ? FWD_RF : fwd_b;
    assign hz.mem_err   = mem_err_q;

    assign lu = hz.LoadE && (hz.RdE != 5'd0) && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        hz.StallF  = 1'b0;
        hz.StallD  = 1'b0;
        hz.StallE  = 1'b0;
        hz.StallM  = 1'b0;
        hz.FlushD  = 1'b0;
        hz.FlushE  = 1'b0;
        case (state_q)
            S_RUN: begin
                hz.StallF = lu;
                hz.StallD = lu;
                hz.FlushD = hz.PCSrcE;
                hz.FlushE = lu | hz.PCSrcE;
                if (hz.MemReqM && !hz.MemReadyM) begin
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            S_MEM_WAIT: begin
                // Whole pipe frozen; lu and PCSrcE are re-evaluated once E moves again.
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                if (hz.MemReadyM) begin
                    state_d = S_RUN;
                end else if (wait_cnt_q == CW'(MEM_TIMEOUT)) begin
                    mem_err_d = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
        if (rst) begin
            hz.StallF = 1'b0;
            hz.StallD = 1'b0;
            hz.StallE = 1'b0;
            hz.StallM = 1'b0;
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] lu_cnt_q, flush_cnt_q, wait_perf_q;

    // Counters saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
            wait_perf_q <= '0;
        end else begin
            if ((state_q == S_RUN) && lu && !(&lu_cnt_q)) begin
                lu_cnt_q <= lu_cnt_q + 1'b1;
            end
            if ((state_q == S_RUN) && hz.PCSrcE && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if ((state_q == S_MEM_WAIT) && !(&wait_perf_q)) begin
                wait_perf_q <= wait_perf_q + 1'b1;
            end
        end
    end

    assign hz.perf_lu_cnt    = lu_cnt_q;
    assign hz.perf_flush_cnt = flush_cnt_q;
    assign hz.perf_wait_cnt  = wait_perf_q;
`else
    assign hz.perf_lu_cnt    = '0;
    assign hz.perf_flush_cnt = '0;
    assign hz.perf_wait_cnt  = '0;
`endif

endmodule
